// File: rtl/mixer_pkg.sv
// Constants and the detent direction encoding shared by the mixer top level and its channels.
package mixer_pkg;

    localparam int CH_IDX_W = 3;
    localparam int MAX_CH   = 8;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/mixer_channel.sv
// One mixer channel: encoder synchronisers and debouncers, detent decoding,
// the level register with direct-write override, and the PWM duty shadow.
module mixer_channel
    import mixer_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int HIST_LEN = 8,
    parameter int STEP     = 1,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_encA,
    input  logic             i_encB,
    input  logic             i_debStrobe,
    input  logic             i_loadEn,
    input  logic [WIDTH-1:0] i_loadValue,
    input  logic             i_dutyLatch,
    output logic [WIDTH-1:0] o_level,
    output logic [WIDTH-1:0] o_duty
);

    localparam logic [WIDTH:0] STEP_X = (WIDTH + 1)'(STEP);

    logic [1:0]          r_sync [2];
    logic [HIST_LEN-1:0] r_hist [2];
    logic [1:0]          r_deb;
    logic                r_debAPrev;
    logic [WIDTH-1:0]    r_level;
    logic [WIDTH-1:0]    r_duty;
    logic [1:0]          w_raw;
    logic                w_detent;
    dir_e                w_dir;
    logic [WIDTH:0]      w_sum;
    logic [WIDTH:0]      w_diff;
    logic [WIDTH-1:0]    w_next;

    assign w_raw    = {i_encB, i_encA};
    assign w_detent = r_deb[0] & ~r_debAPrev;
    assign w_dir    = dir_e'(r_deb[1]);
    assign w_sum    = {1'b0, r_level} + STEP_X;
    assign w_diff   = {1'b0, r_level} - STEP_X;

    // Index 0 is contact A, index 1 is contact B; the debounced bit only moves on a unanimous history.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_sync[i] <= '0;
                r_hist[i] <= '0;
            end
            r_deb      <= '0;
            r_debAPrev <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_sync[i] <= {r_sync[i][0], w_raw[i]};
                if (i_debStrobe) begin
                    r_hist[i] <= {r_hist[i][HIST_LEN-2:0], r_sync[i][1]};
                end
                if (&r_hist[i]) begin
                    r_deb[i] <= 1'b1;
                end else if (~|r_hist[i]) begin
                    r_deb[i] <= 1'b0;
                end
            end
            r_debAPrev <= r_deb[0];
        end
    end

    // Bit WIDTH of the widened sum/difference flags overflow or borrow.
    always_comb begin
        w_next = r_level;
        if (w_detent) begin
            if (w_dir == DIR_UP) begin
                w_next = (SATURATE && w_sum[WIDTH]) ? '1 : w_sum[WIDTH-1:0];
            end else begin
                w_next = (SATURATE && w_diff[WIDTH]) ? '0 : w_diff[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= '0;
            r_duty  <= '0;
        end else begin
            r_level <= i_loadEn ? i_loadValue : w_next;
            if (i_dutyLatch) begin
                r_duty <= r_level;
            end
        end
    end

    assign o_level = r_level;
    assign o_duty  = r_duty;

endmodule

// File: rtl/multi_channel_mixer.sv
// Multi-channel rotary-encoder mixer: per-channel levels set by quadrature detents
// or direct writes, each rendered as a glitch-free, optionally phase-staggered PWM.
module multi_channel_mixer
    import mixer_pkg::*;
#(
    parameter int NUM_CH    = 3,
    parameter int WIDTH     = 8,
    parameter int HIST_LEN  = 8,
    parameter int DEB_DIV_W = 8,
    parameter int PWM_DIV_W = 4,
    parameter int STEP      = 1,
    parameter bit SATURATE  = 1'b1,
    parameter bit STAGGER   = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       enc_a,
    input  logic [NUM_CH-1:0]       enc_b,
    input  logic                    load_valid,
    input  logic [CH_IDX_W-1:0]     load_ch,
    input  logic [WIDTH-1:0]        load_value,
    output logic [NUM_CH*WIDTH-1:0] level,
    output logic [NUM_CH-1:0]       pwm_out
);

    logic [DEB_DIV_W-1:0] r_debDiv;
    logic [PWM_DIV_W-1:0] r_pwmDiv;
    logic [WIDTH-1:0]     r_pwmCnt;
    logic [NUM_CH-1:0]    r_pwm;
    logic                 w_debStrobe;
    logic                 w_pwmStrobe;
    logic                 w_pwmWrap;
    logic [WIDTH-1:0]     w_duty [NUM_CH];
    logic [NUM_CH-1:0]    w_pwmNext;

    assign w_debStrobe = &r_debDiv;
    assign w_pwmStrobe = &r_pwmDiv;
    // Duty shadows reload only as the counter wraps, so a running period is never altered.
    assign w_pwmWrap   = w_pwmStrobe && (&r_pwmCnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_debDiv <= '0;
            r_pwmDiv <= '0;
            r_pwmCnt <= '0;
            r_pwm    <= '0;
        end else begin
            r_debDiv <= r_debDiv + DEB_DIV_W'(1);
            r_pwmDiv <= r_pwmDiv + PWM_DIV_W'(1);
            if (w_pwmStrobe) begin
                r_pwmCnt <= r_pwmCnt + WIDTH'(1);
            end
            r_pwm <= w_pwmNext;
        end
    end

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            localparam logic [WIDTH-1:0] PHASE =
                STAGGER ? WIDTH'(c * ((2 ** WIDTH) / NUM_CH)) : '0;

            logic             w_loadEn;
            logic [WIDTH-1:0] w_phaseCnt;

            // Writes addressed beyond NUM_CH match no channel and are dropped.
            assign w_loadEn     = load_valid && (load_ch == CH_IDX_W'(c));
            assign w_phaseCnt   = r_pwmCnt + PHASE;
            assign w_pwmNext[c] = w_phaseCnt < w_duty[c];

            mixer_channel #(
                .WIDTH    (WIDTH),
                .HIST_LEN (HIST_LEN),
                .STEP     (STEP),
                .SATURATE (SATURATE)
            ) u_channel (
                .clk         (clk),
                .reset       (reset),
                .i_encA      (enc_a[c]),
                .i_encB      (enc_b[c]),
                .i_debStrobe (w_debStrobe),
                .i_loadEn    (w_loadEn),
                .i_loadValue (load_value),
                .i_dutyLatch (w_pwmWrap),
                .o_level     (level[c*WIDTH +: WIDTH]),
                .o_duty      (w_duty[c])
            );
        end
    endgenerate

    assign pwm_out = r_pwm;

endmodule

// File: tb/tb_multi_channel_mixer.sv
// Bench for multi_channel_mixer: a saturating and a wrapping instance share every input,
// so one stimulus stream exercises both arithmetic modes.
module tb_multi_channel_mixer;

    localparam int DEB_PERIOD = 256;
    localparam int PWM_PERIOD = 4096;
    localparam int HOLD       = 9 * DEB_PERIOD;

    typedef enum int { OP_LOAD, OP_DETENT } op_e;

    typedef struct {
        op_e         op;
        logic [2:0]  ch;
        logic [7:0]  value;
        logic [2:0]  mask;
        logic        down;
        logic [23:0] expSat;
        logic [23:0] expWrap;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  enc_a = '0;
    logic [2:0]  enc_b = '0;
    logic        load_valid = 1'b0;
    logic [2:0]  load_ch = '0;
    logic [7:0]  load_value = '0;
    logic [23:0] level;
    logic [23:0] levelWrap;
    logic [2:0]  pwm_out;
    logic [2:0]  pwmWrap;

    int   checks = 0;
    int   errors = 0;
    int   edgeCnt = 0;
    vec_t vecs[8];
    int   badMain, badWrap, n, step, duty;
    int   hi[3], hiW[3], mism[3], rise[3];
    int   oldDuty[3];
    int   stagL, stagW;
    logic expBit;
    logic [2:0] prevPwm;

    multi_channel_mixer dut (
        .clk        (clk),
        .reset      (reset),
        .enc_a      (enc_a),
        .enc_b      (enc_b),
        .load_valid (load_valid),
        .load_ch    (load_ch),
        .load_value (load_value),
        .level      (level),
        .pwm_out    (pwm_out)
    );

    multi_channel_mixer #(.SATURATE(1'b0)) dutWrap (
        .clk        (clk),
        .reset      (reset),
        .enc_a      (enc_a),
        .enc_b      (enc_b),
        .load_valid (load_valid),
        .load_ch    (load_ch),
        .load_value (load_value),
        .level      (levelWrap),
        .pwm_out    (pwmWrap)
    );

    always #5 clk = ~clk;

    // Edges since reset release; both strobe dividers are phase-locked to it.
    always @(posedge clk) begin
        if (reset) edgeCnt <= 0;
        else       edgeCnt <= edgeCnt + 1;
    end

    function automatic vec_t mkVec(op_e op, logic [2:0] ch, logic [7:0] value, logic [2:0] mask,
                                   logic down, logic [23:0] expSat, logic [23:0] expWrap);
        vec_t v;
        v.op = op; v.ch = ch; v.value = value; v.mask = mask; v.down = down;
        v.expSat = expSat; v.expWrap = expWrap;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int cnt);
        repeat (cnt) @(negedge clk);
    endtask

    task automatic alignTo(input int period, input int phase);
        while (edgeCnt % period != phase) @(negedge clk);
    endtask

    task automatic loadLevel(input logic [2:0] ch, input logic [7:0] value);
        load_valid = 1'b1;
        load_ch    = ch;
        load_value = value;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic detent(input logic [2:0] mask, input logic down);
        alignTo(DEB_PERIOD, 0);
        for (int c = 0; c < 3; c++) begin
            if (mask[c]) begin
                enc_b[c] = down;
                enc_a[c] = 1'b1;
            end
        end
        waitCycles(HOLD);
        enc_a = enc_a & ~mask;
        waitCycles(HOLD);
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.op == OP_LOAD) loadLevel(v.ch, v.value);
        else                 detent(v.mask, v.down);
        waitCycles(2);
    endtask

    initial begin
        vecs[0] = mkVec(OP_LOAD,   3'd1, 8'd254, 3'b000, 1'b0, 24'h00FE00, 24'h00FE00);
        vecs[1] = mkVec(OP_DETENT, 3'd0, 8'd0,   3'b011, 1'b0, 24'h00FF01, 24'h00FF01);
        vecs[2] = mkVec(OP_DETENT, 3'd0, 8'd0,   3'b011, 1'b0, 24'h00FF02, 24'h000002);
        vecs[3] = mkVec(OP_DETENT, 3'd0, 8'd0,   3'b011, 1'b0, 24'h00FF03, 24'h000103);
        vecs[4] = mkVec(OP_DETENT, 3'd0, 8'd0,   3'b100, 1'b1, 24'h00FF03, 24'hFF0103);
        vecs[5] = mkVec(OP_LOAD,   3'd5, 8'h11,  3'b000, 1'b0, 24'h00FF03, 24'hFF0103);
        vecs[6] = mkVec(OP_LOAD,   3'd2, 8'h10,  3'b000, 1'b0, 24'h10FF03, 24'h100103);
        vecs[7] = mkVec(OP_DETENT, 3'd0, 8'd0,   3'b100, 1'b1, 24'h0FFF03, 24'h0F0103);

        waitCycles(3);
        checkOutput("reset_level", 32'(level), 32'h0);
        checkOutput("reset_pwm", 32'(pwm_out), 32'h0);
        checkOutput("reset_level_wrap", 32'(levelWrap), 32'h0);
        checkOutput("reset_pwm_wrap", 32'(pwmWrap), 32'h0);
        reset = 1'b0;

        badMain = 0; badWrap = 0;
        repeat (600) begin
            @(negedge clk);
            if (level !== 24'h0 || pwm_out !== 3'b000) badMain++;
            if (levelWrap !== 24'h0 || pwmWrap !== 3'b000) badWrap++;
        end
        checkOutput("idle_bad_cycles", 32'(badMain), 32'h0);
        checkOutput("idle_bad_cycles_wrap", 32'(badWrap), 32'h0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].expSat));
            checkOutput($sformatf("vec%0d_level_wrap", i), 32'(levelWrap), 32'(vecs[i].expWrap));
        end

        alignTo(PWM_PERIOD, 0);
        for (int c = 0; c < 3; c++) begin hi[c] = 0; hiW[c] = 0; end
        repeat (PWM_PERIOD) begin
            @(negedge clk);
            for (int c = 0; c < 3; c++) begin
                hi[c]  += int'(pwm_out[c]);
                hiW[c] += int'(pwmWrap[c]);
            end
        end
        checkOutput("pwm_high_ch0", 32'(hi[0]), 32'd48);
        checkOutput("pwm_high_ch1", 32'(hi[1]), 32'd4080);
        checkOutput("pwm_high_ch2", 32'(hi[2]), 32'd240);
        checkOutput("pwm_high_ch0_wrap", 32'(hiW[0]), 32'd48);
        checkOutput("pwm_high_ch1_wrap", 32'(hiW[1]), 32'd16);
        checkOutput("pwm_high_ch2_wrap", 32'(hiW[2]), 32'd240);

        // The ch2 detent lands 2050 edges after A rises; the write window straddles it.
        alignTo(DEB_PERIOD, 0);
        enc_b[2] = 1'b0;
        enc_a[2] = 1'b1;
        waitCycles(2048 - 3);
        load_valid = 1'b1; load_ch = 3'd2; load_value = 8'h80;
        badMain = 0; badWrap = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (level[23:16] !== 8'h80) badMain++;
            if (levelWrap[23:16] !== 8'h80) badWrap++;
        end
        load_valid = 1'b0;
        waitCycles(HOLD - 2045 - 8);
        enc_a[2] = 1'b0;
        waitCycles(HOLD);
        checkOutput("override_window", 32'(badMain), 32'h0);
        checkOutput("override_window_wrap", 32'(badWrap), 32'h0);
        checkOutput("override_level", 32'(level), 32'h80FF03);
        checkOutput("override_level_wrap", 32'(levelWrap), 32'h800103);

        alignTo(DEB_PERIOD, 0);
        enc_b[0] = 1'b0;
        repeat (5 * DEB_PERIOD) begin
            enc_a[0] = ~enc_a[0];
            @(negedge clk);
        end
        enc_a[0] = 1'b1;
        waitCycles(HOLD);
        enc_a[0] = 1'b0;
        waitCycles(HOLD);
        checkOutput("bounce_level", 32'(level), 32'h80FF04);
        checkOutput("bounce_level_wrap", 32'(levelWrap), 32'h800104);

        alignTo(PWM_PERIOD, 0);
        alignTo(PWM_PERIOD, 2048);
        stagL = edgeCnt;
        stagW = stagL + 2048;
        oldDuty[0] = 4; oldDuty[1] = 255; oldDuty[2] = 128;
        for (int c = 0; c < 3; c++) begin mism[c] = 0; rise[c] = -1; end
        prevPwm = pwm_out;
        for (int k = 1; k <= 2 * PWM_PERIOD; k++) begin
            if (k <= 3) begin
                load_valid = 1'b1; load_ch = 3'(k - 1); load_value = 8'd85;
            end else begin
                load_valid = 1'b0;
            end
            @(negedge clk);
            n = edgeCnt;
            step = ((n - 1) / 16) % 256;
            for (int c = 0; c < 3; c++) begin
                duty = (n - 1 >= stagW) ? 85 : oldDuty[c];
                expBit = (((step + c * 85) % 256) < duty);
                if (pwm_out[c] !== expBit) mism[c]++;
                if (n > stagW && rise[c] < 0 && !prevPwm[c] && pwm_out[c]) rise[c] = step;
            end
            prevPwm = pwm_out;
        end
        checkOutput("stagger_bad_cycles_ch0", 32'(mism[0]), 32'h0);
        checkOutput("stagger_bad_cycles_ch1", 32'(mism[1]), 32'h0);
        checkOutput("stagger_bad_cycles_ch2", 32'(mism[2]), 32'h0);
        checkOutput("stagger_rise_step_ch0", 32'(rise[0]), 32'd0);
        checkOutput("stagger_rise_step_ch1", 32'(rise[1]), 32'd171);
        checkOutput("stagger_rise_step_ch2", 32'(rise[2]), 32'd86);

        alignTo(PWM_PERIOD, 1000);
        reset = 1'b1;
        waitCycles(2);
        checkOutput("midrun_reset_level", 32'(level), 32'h0);
        checkOutput("midrun_reset_pwm", 32'(pwm_out), 32'h0);
        checkOutput("midrun_reset_level_wrap", 32'(levelWrap), 32'h0);
        reset = 1'b0;
        load_valid = 1'b1; load_ch = 3'd0; load_value = 8'd200;
        @(negedge clk);
        load_valid = 1'b0;
        checkOutput("post_reset_load", 32'(level), 32'd200);
        badMain = 0; badWrap = 0;
        while (edgeCnt % PWM_PERIOD != 0) begin
            @(negedge clk);
            if (pwm_out !== 3'b000) badMain++;
            if (pwmWrap !== 3'b000) badWrap++;
        end
        checkOutput("pre_wrap_pwm_high_cycles", 32'(badMain), 32'h0);
        checkOutput("pre_wrap_pwm_high_cycles_wrap", 32'(badWrap), 32'h0);
        @(negedge clk);
        checkOutput("post_wrap_pwm", 32'(pwm_out), 32'b001);
        checkOutput("post_wrap_pwm_wrap", 32'(pwmWrap), 32'b001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
